// File: rtl/spi_frame_scheduler_pkg.sv
// Shared types and constants for the SPI frame scheduler.
//   sched_state_t : scheduler FSM states
//   err_code_t    : error codes reported on last_err
//   HDR_*_DEF     : default header opcodes
//   sat_inc8      : saturating 8-bit increment for the error counter
package spi_frame_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HEADER  = 3'd1,
      PAYLOAD = 3'd2,
      TAIL    = 3'd3,
      DISCARD = 3'd4,
      PENDING = 3'd5,
      COMMIT  = 3'd6
   } sched_state_t;

   typedef enum logic [1:0] {
      ERR_BAD_HDR = 2'd0,
      ERR_SHORT   = 2'd1,
      ERR_LONG    = 2'd2,
      ERR_OVERRUN = 2'd3
   } err_code_t;

   localparam logic [7:0] HDR_FRAME_DEF = 8'hA5;
   localparam logic [7:0] HDR_CLEAR_DEF = 8'h5A;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/spi_frame_scheduler_if.sv
// Bus bundle between the SPI byte receiver / state_manager side and the
// frame scheduler.
//   slave  : scheduler view (SPI/vsync/ack in, frame request + status out)
//   master : environment view (the opposite directions)
// Handshake: GAME_new_frame_ready is a request held high until frame_ack is
// sampled high while it is asserted; GAME_frame_data is stable throughout.
// spi_byte is qualified by the one-cycle strobe spi_byte_valid.
interface spi_frame_scheduler_if #(parameter int PAYLOAD_BYTES = 4) ();
   import spi_frame_pkg::*;

   logic                       ce;
   logic [7:0]                 spi_byte;
   logic                       spi_byte_valid;
   logic                       v_sync;
   logic                       frame_ack;
   logic                       GAME_new_frame_ready;
   logic [8*PAYLOAD_BYTES-1:0] GAME_frame_data;
   logic                       busy;
   logic [7:0]                 err_count;
   logic [1:0]                 last_err;
   sched_state_t               state_dbg;

   modport slave (
      input  ce, spi_byte, spi_byte_valid, v_sync, frame_ack,
      output GAME_new_frame_ready, GAME_frame_data, busy, err_count,
             last_err, state_dbg
   );

   modport master (
      output ce, spi_byte, spi_byte_valid, v_sync, frame_ack,
      input  GAME_new_frame_ready, GAME_frame_data, busy, err_count,
             last_err, state_dbg
   );

endinterface

// File: rtl/spi_frame_scheduler_sync_2ff.sv
// Generic two-flop synchronizer.
//   clk, rst_n : clock and asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output (RESET_VAL while in reset)
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/spi_frame_scheduler.sv
// Assembles SPI bytes into a frame packet, validates it, and commits it to
// the state manager at the start of vertical sync via a request/ack.
//   VGA_clk, reset_n : sole clock, asynchronous active-low reset
//   bus (slave)      : ce/spi_byte/spi_byte_valid/v_sync/frame_ack in;
//                      GAME_new_frame_ready/GAME_frame_data/busy/
//                      err_count/last_err/state_dbg out
module spi_frame_scheduler
   import spi_frame_pkg::*;
#(
   parameter int         PAYLOAD_BYTES    = 4,
   parameter logic [7:0] HDR_FRAME        = HDR_FRAME_DEF,
   parameter logic [7:0] HDR_CLEAR        = HDR_CLEAR_DEF,
   parameter bit         VSYNC_ACTIVE_LOW = 1'b1
) (
   input  logic                  VGA_clk,
   input  logic                  reset_n,
   spi_frame_scheduler_if.slave  bus
);

   localparam int         DW       = 8 * PAYLOAD_BYTES;
   localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

   sched_state_t state_q, state_d, st_mid;
   logic [3:0]   cnt_q, cnt_d;
   logic [DW-1:0] shadow_q, shadow_d, data_q, data_d;
   logic         ready_q, ready_d;
   logic [7:0]   err_cnt_q, err_cnt_d;
   logic [1:0]   last_err_q, last_err_d;
   logic         ce_s, ce_prev_q, vs_act_q, vs_act_qq;
   logic [3:0]   err_vec;

   sync_2ff #(.RESET_VAL(1'b1)) u_ce_sync (
      .clk(VGA_clk), .rst_n(reset_n), .d(bus.ce), .q(ce_s)
   );

   wire ce_start = ce_prev_q & ~ce_s;
   wire ce_end   = ~ce_prev_q & ce_s;
   // The byte that arrives together with ce_end still belongs to the packet.
   wire byte_ok  = bus.spi_byte_valid & (~ce_s | ce_end);
   wire vs_act   = bus.v_sync ^ VSYNC_ACTIVE_LOW;
   wire vs_start = vs_act_q & ~vs_act_qq;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      data_d     = data_q;
      ready_d    = ready_q;
      err_cnt_d  = err_cnt_q;
      last_err_d = last_err_q;
      err_vec    = 4'b0000;

      // Byte stage runs first; the ce_end stage then acts on its result.
      st_mid = state_q;
      if (byte_ok) begin
         case (state_q)
            HEADER: begin
               if (bus.spi_byte == HDR_FRAME) begin
                  st_mid = PAYLOAD;
               end else if (bus.spi_byte == HDR_CLEAR) begin
                  shadow_d = '0;
                  st_mid   = TAIL;
               end else begin
                  st_mid = DISCARD;
                  err_vec[ERR_BAD_HDR] = 1'b1;
               end
            end
            PAYLOAD: begin
               shadow_d[{cnt_q, 3'b000} +: 8] = bus.spi_byte;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == LAST_IDX) st_mid = TAIL;
            end
            TAIL: begin
               st_mid = DISCARD;
               err_vec[ERR_LONG] = 1'b1;
            end
            default: ;
         endcase
      end

      state_d = st_mid;
      if (ce_end) begin
         case (st_mid)
            HEADER:  state_d = IDLE;
            PAYLOAD: begin
               state_d = IDLE;
               err_vec[ERR_SHORT] = 1'b1;
            end
            TAIL:    state_d = PENDING;
            DISCARD: state_d = IDLE;
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (ce_start) begin
               state_d = HEADER;
               cnt_d   = 4'd0;
            end
         end
         PENDING: begin
            if (vs_start) begin
               state_d = COMMIT;
               data_d  = shadow_q;
               ready_d = 1'b1;
            end
            if (ce_start) err_vec[ERR_OVERRUN] = 1'b1;
         end
         COMMIT: begin
            if (bus.frame_ack) begin
               ready_d = 1'b0;
               state_d = ce_s ? IDLE : DISCARD;
            end
            if (ce_start) err_vec[ERR_OVERRUN] = 1'b1;
         end
         default: ;
      endcase

      if (err_vec != 4'b0000) begin
         err_cnt_d = sat_inc8(err_cnt_q);
         if (err_vec[3])      last_err_d = 2'd3;
         else if (err_vec[2]) last_err_d = 2'd2;
         else if (err_vec[1]) last_err_d = 2'd1;
         else                 last_err_d = 2'd0;
      end
   end

   always_ff @(posedge VGA_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shadow_q   <= '0;
         data_q     <= '0;
         ready_q    <= 1'b0;
         err_cnt_q  <= '0;
         last_err_q <= '0;
         ce_prev_q  <= 1'b1;
         vs_act_q   <= 1'b0;
         vs_act_qq  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         data_q     <= data_d;
         ready_q    <= ready_d;
         err_cnt_q  <= err_cnt_d;
         last_err_q <= last_err_d;
         ce_prev_q  <= ce_s;
         vs_act_q   <= vs_act;
         vs_act_qq  <= vs_act_q;
      end
   end

   assign bus.GAME_new_frame_ready = ready_q;
   assign bus.GAME_frame_data      = data_q;
   assign bus.busy                 = (state_q != IDLE);
   assign bus.err_count            = err_cnt_q;
   assign bus.last_err             = last_err_q;
   assign bus.state_dbg            = state_q;

endmodule
